// File: rtl/pkt_mc_pkg.sv
// ariane_soc: fuse-word destination addresses and shared types for the pkt_mc key table.
package ariane_soc;
    localparam int PKT_DEPTH = 34;
    localparam int PKT_AW    = $clog2(PKT_DEPTH);
    localparam logic [63:0] AESKey0_0 = 64'h0000_0000_1010_0008;
    localparam logic [63:0] AESKey0_1 = 64'h0000_0000_1010_000C;
    localparam logic [63:0] AESKey0_2 = 64'h0000_0000_1010_0010;
    localparam logic [63:0] AESKey0_3 = 64'h0000_0000_1010_0014;
    localparam logic [63:0] AESKey0_4 = 64'h0000_0000_1010_0018;
    localparam logic [63:0] AESKey0_5 = 64'h0000_0000_1010_001C;
    localparam logic [63:0] AESKey1_0 = 64'h0000_0000_1010_0108;
    localparam logic [63:0] AESKey1_1 = 64'h0000_0000_1010_010C;
    localparam logic [63:0] AESKey1_2 = 64'h0000_0000_1010_0110;
    localparam logic [63:0] AESKey1_3 = 64'h0000_0000_1010_0114;
    localparam logic [63:0] AESKey1_4 = 64'h0000_0000_1010_0118;
    localparam logic [63:0] AESKey1_5 = 64'h0000_0000_1010_011C;
    localparam logic [63:0] AESKey2_0 = 64'h0000_0000_1010_0208;
    localparam logic [63:0] AESKey2_1 = 64'h0000_0000_1010_020C;
    localparam logic [63:0] AESKey2_2 = 64'h0000_0000_1010_0210;
    localparam logic [63:0] AESKey2_3 = 64'h0000_0000_1010_0214;
    localparam logic [63:0] AESKey2_4 = 64'h0000_0000_1010_0218;
    localparam logic [63:0] AESKey2_5 = 64'h0000_0000_1010_021C;
    localparam logic [63:0] SHAKey_0  = 64'h0000_0000_1020_0040;
    localparam logic [63:0] SHAKey_1  = 64'h0000_0000_1020_0044;
    localparam logic [63:0] SHAKey_2  = 64'h0000_0000_1020_0048;
    localparam logic [63:0] SHAKey_3  = 64'h0000_0000_1020_004C;
    localparam logic [63:0] SHAKey_4  = 64'h0000_0000_1020_0050;
    localparam logic [63:0] SHAKey_5  = 64'h0000_0000_1020_0054;
    localparam logic [63:0] SHAKey_6  = 64'h0000_0000_1020_0058;
    localparam logic [63:0] SHAKey_7  = 64'h0000_0000_1020_005C;
    localparam logic [63:0] AcCt_0    = 64'h0000_0000_1030_0000;
    localparam logic [63:0] AcCt_1    = 64'h0000_0000_1030_0004;
    localparam logic [63:0] AcCt_2    = 64'h0000_0000_1030_0008;
    localparam logic [63:0] AcCt_3    = 64'h0000_0000_1030_000C;
    localparam logic [63:0] AcCt_4    = 64'h0000_0000_1030_0010;
    localparam logic [63:0] AcCt_5    = 64'h0000_0000_1030_0014;
    localparam logic [63:0] AcCt_6    = 64'h0000_0000_1030_0018;
    localparam logic [63:0] JTAGKEY   = 64'h0000_0000_1040_0000;

    localparam logic [63:0] PKT_DEFAULT_TABLE [PKT_DEPTH] = '{
        AESKey0_0, AESKey0_1, AESKey0_2, AESKey0_3, AESKey0_4, AESKey0_5,
        AESKey1_0, AESKey1_1, AESKey1_2, AESKey1_3, AESKey1_4, AESKey1_5,
        AESKey2_0, AESKey2_1, AESKey2_2, AESKey2_3, AESKey2_4, AESKey2_5,
        SHAKey_0, SHAKey_1, SHAKey_2, SHAKey_3, SHAKey_4, SHAKey_5, SHAKey_6, SHAKey_7,
        AcCt_0, AcCt_1, AcCt_2, AcCt_3, AcCt_4, AcCt_5, AcCt_6, JTAGKEY
    };

    typedef struct packed {
        logic [63:0] loc;
        logic        err;
    } pkt_rsp_t;

    typedef enum logic {CH_EMPTY, CH_FULL} pkt_ch_state_e;

    // Entries beyond the default table (larger DEPTH builds) start at zero.
    function automatic logic [63:0] pkt_default(input int i);
        return (i >= 0 && i < PKT_DEPTH) ? PKT_DEFAULT_TABLE[i[PKT_AW-1:0]] : 64'h0;
    endfunction
endpackage

// File: rtl/pkt_mc_rr_arb.sv
// pkt_rr_arb: round-robin arbiter, one-hot grant, pointer moves past the last winner.
module pkt_rr_arb #(
    parameter int NUM_CH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] i_elig,
    output logic [NUM_CH-1:0] o_gnt
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;
    logic [PW-1:0] w_c;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_nxt   = r_ptr;
        w_c     = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_c = PW'((int'(r_ptr) + k) % NUM_CH);
            if (!w_found && i_elig[w_c]) begin
                o_gnt[w_c] = 1'b1;
                w_nxt      = PW'((int'(r_ptr) + k + 1) % NUM_CH);
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_ptr <= '0;
        else         r_ptr <= w_nxt;
endmodule

// File: rtl/pkt_mc.sv
// pkt_mc: multi-channel fuse-index to destination-address lookup with round-robin arbitration.
// Define PKT_RUNTIME_WR_EN to make the table writable (with sticky lock) instead of constant.
module pkt_mc
    import ariane_soc::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = PKT_DEPTH,
    parameter int IDX_W  = 32,
    parameter int ADDR_W = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CH-1:0]             req_valid_i,
    output logic [NUM_CH-1:0]             req_ready_o,
    input  logic [NUM_CH-1:0][IDX_W-1:0]  req_indx_i,
    output logic [NUM_CH-1:0]             rsp_valid_o,
    input  logic [NUM_CH-1:0]             rsp_ready_i,
    output logic [NUM_CH-1:0][ADDR_W-1:0] rsp_loc_o,
    output logic [NUM_CH-1:0]             rsp_err_o,
    input  logic                          wr_en_i,
    input  logic [IDX_W-1:0]              wr_indx_i,
    input  logic [ADDR_W-1:0]             wr_data_i,
    input  logic                          lock_i,
    output logic                          locked_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] w_tab [DEPTH];
    logic [NUM_CH-1:0] w_drain;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_inr;
    pkt_rsp_t          w_lk;

    assign w_drain = rsp_valid_o & rsp_ready_i;
    assign w_elig  = req_valid_i & (~rsp_valid_o | w_drain);

    pkt_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_elig (w_elig),
        .o_gnt  (w_gnt)
    );

    assign req_ready_o = w_gnt & {NUM_CH{rst_ni}};

    // Single shared lookup: the grant is one-hot, so OR-ing selects the winner's index.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NUM_CH; k++)
            w_idx = w_idx | (w_gnt[k] ? req_indx_i[k] : '0);
    end

    assign w_inr    = w_idx < IDX_W'(DEPTH);
    assign w_lk.loc = w_inr ? 64'(w_tab[w_idx[AW-1:0]]) : 64'({ADDR_W{1'b1}});
    assign w_lk.err = ~w_inr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pkt_ch_state_e r_st;
        pkt_rsp_t      r_rsp;
        always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) begin
                r_st  <= CH_EMPTY;
                r_rsp <= '0;
            end else if (req_ready_o[c]) begin
                r_st  <= CH_FULL;
                r_rsp <= w_lk;
            end else if (w_drain[c]) begin
                r_st  <= CH_EMPTY;
            end
        assign rsp_valid_o[c] = r_st == CH_FULL;
        assign rsp_loc_o[c]   = ADDR_W'(r_rsp.loc);
        assign rsp_err_o[c]   = r_rsp.err;
    end

`ifdef PKT_RUNTIME_WR_EN
    logic [ADDR_W-1:0] r_table [DEPTH];
    logic              r_locked;
    logic              w_wr;

    assign w_wr = wr_en_i & ~r_locked & (wr_indx_i < IDX_W'(DEPTH));

    // Lock is sampled alongside the write, so a same-cycle write still lands.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= ADDR_W'(pkt_default(i));
            r_locked <= 1'b0;
        end else begin
            if (w_wr)   r_table[wr_indx_i[AW-1:0]] <= wr_data_i;
            if (lock_i) r_locked <= 1'b1;
        end

    assign w_tab    = r_table;
    assign locked_o = r_locked;
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign w_tab[i] = ADDR_W'(pkt_default(i));
    end

    logic w_unused;
    assign w_unused = ^{wr_en_i, wr_indx_i, wr_data_i, lock_i};
    assign locked_o = 1'b1;
`endif
endmodule
